arithmetic_shifter: RTL and testbench

//   Registered arithmetic barrel shifter for the datapath.
//   - Shifts a signed data word left or right by a run-time amount.
//   - Right shifts replicate the sign bit; left shifts fill with zeros.
//   - One-cycle registered result, so it drops into a pipelined ALU/execute stage.

---
 rtl/arithmetic_shifter_if.sv | 24 ++
 rtl/arithmetic_shifter.sv | 71 +++++++
 tb/tb_arithmetic_shifter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/arithmetic_shifter_if.sv
// Operand/result bundle for the arithmetic shifter.
// The master drives the shift command and operand; the slave returns the
// registered result together with its valid flag.
interface arithmetic_shifter_if #(
  parameter int WIDTH     = 32,
  parameter int AMT_WIDTH = 32
);
  logic                 Sh_dir;   // 0 = arithmetic right, 1 = left
  logic [AMT_WIDTH-1:0] Sh_amt;   // unsigned shift amount
  logic [WIDTH-1:0]     D_in;     // two's-complement operand
  logic                 in_vld;   // operands valid this cycle
  logic [WIDTH-1:0]     D_out;    // registered result
  logic                 out_vld;  // D_out holds the result of last cycle's in_vld

  modport master (
    output Sh_dir, Sh_amt, D_in, in_vld,
    input  D_out, out_vld
  );

  modport slave (
    input  Sh_dir, Sh_amt, D_in, in_vld,
    output D_out, out_vld
  );
endinterface

// File: rtl/arithmetic_shifter.sv
// Registered arithmetic barrel shifter.
// log2(WIDTH) conditional shift-by-2^k stages, a saturation override for
// amounts >= WIDTH, and a single output register that only loads on in_vld.
// Right shifts replicate the sign bit; left shifts fill with zeros.
module arithmetic_shifter #(
  parameter int WIDTH     = 32,
  parameter int AMT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  arithmetic_shifter_if.slave bus
);

  localparam int LOG2 = $clog2(WIDTH);

  // Low amount bits steer the mux stages; anything above them saturates.
  logic [LOG2-1:0]  amt_low;
  logic             amt_sat;
  logic [WIDTH-1:0] shifted;

  // Split the amount port into stage-select bits and a saturation flag,
  // adapting to amount ports narrower, equal to or wider than log2(WIDTH).
  generate
    if (AMT_WIDTH > LOG2) begin : g_amt_wide
      assign amt_low = bus.Sh_amt[LOG2-1:0];
      assign amt_sat = |bus.Sh_amt[AMT_WIDTH-1:LOG2];
    end else if (AMT_WIDTH == LOG2) begin : g_amt_exact
      assign amt_low = bus.Sh_amt;
      assign amt_sat = 1'b0;
    end else begin : g_amt_narrow
      assign amt_low = {{(LOG2-AMT_WIDTH){1'b0}}, bus.Sh_amt};
      assign amt_sat = 1'b0;
    end
  endgenerate

  // Barrel shifter: stage k shifts by 2^k when amount bit k is set, then the
  // saturation override forces all-sign (right) or all-zero (left).
  always_comb begin
    logic [WIDTH-1:0] acc;
    // NOTE: every variable assigned here gets a value on all paths before any
    // conditional logic, so no latch can be inferred.
    acc     = bus.D_in;
    shifted = '0;
    for (int k = 0; k < LOG2; k++) begin
      if (amt_low[k]) begin
        if (bus.Sh_dir) acc = acc << (1 << k);
        else            acc = $signed(acc) >>> (1 << k);
      end
    end
    if (amt_sat) begin
      shifted = bus.Sh_dir ? '0 : {WIDTH{bus.D_in[WIDTH-1]}};
    end else begin
      shifted = acc;
    end
  end

  // Output register: loads the shifted word on in_vld, otherwise holds;
  // out_vld follows in_vld with one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      bus.D_out   <= '0;
      bus.out_vld <= 1'b0;
    end else begin
      bus.out_vld <= bus.in_vld;
      if (bus.in_vld) bus.D_out <= shifted;
    end
  end

endmodule

// File: tb/tb_arithmetic_shifter.sv
// Directed plus randomised bench for arithmetic_shifter.
// Expected words are pushed to a scoreboard queue as each operand is driven
// and popped when the DUT raises out_vld.
module tb_arithmetic_shifter;

  localparam int WIDTH     = 32;
  localparam int AMT_WIDTH = 32;

  logic clk;
  logic rst;

  arithmetic_shifter_if #(.WIDTH(WIDTH), .AMT_WIDTH(AMT_WIDTH)) bus ();

  arithmetic_shifter #(.WIDTH(WIDTH), .AMT_WIDTH(AMT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] last_out;

  // Behavioural reference for the random phase.
  function automatic logic [WIDTH-1:0] ref_shift(input logic dir,
                                                 input logic [AMT_WIDTH-1:0] amt,
                                                 input logic [WIDTH-1:0] din);
    logic signed [WIDTH-1:0] sd;
    sd = din;
    if (amt >= AMT_WIDTH'(WIDTH)) return dir ? '0 : (din[WIDTH-1] ? '1 : '0);
    if (dir) return din << amt;
    return sd >>> amt;
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, let the DUT clock it, then check out_vld and
  // either the popped scoreboard entry or the held output word.
  task automatic step(input string tag, input logic vld, input logic dir,
                      input logic [AMT_WIDTH-1:0] amt, input logic [WIDTH-1:0] din,
                      input logic [WIDTH-1:0] exp);
    logic [WIDTH-1:0] want;
    bus.in_vld = vld;
    bus.Sh_dir = dir;
    bus.Sh_amt = amt;
    bus.D_in   = din;
    if (vld) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, {{(WIDTH-1){1'b0}}, bus.out_vld}, {{(WIDTH-1){1'b0}}, vld});
    if (bus.out_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_empty"}, bus.D_out, 'x);
      end else begin
        want = sb_q.pop_front();
        chk(tag, bus.D_out, want);
        last_out = want;
      end
    end else begin
      chk({tag, "_hold"}, bus.D_out, last_out);
    end
  endtask

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic                 r_dir;
    logic [AMT_WIDTH-1:0] r_amt;
    logic [WIDTH-1:0]     r_din;

    rst        = 1'b1;
    bus.in_vld = 1'b0;
    bus.Sh_dir = 1'b0;
    bus.Sh_amt = '0;
    bus.D_in   = '0;
    last_out   = '0;
    #1;
    chk("reset_dout", bus.D_out, '0);
    chk("reset_vld",  {{(WIDTH-1){1'b0}}, bus.out_vld}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Right shift of negative and positive operands.
    step("r_neg_1",  1'b1, 1'b0, 32'd1,  32'h8000_0000, 32'hC000_0000);
    step("r_neg_2",  1'b1, 1'b0, 32'd2,  32'h8000_0000, 32'hE000_0000);
    step("r_pos_3",  1'b1, 1'b0, 32'd3,  32'h4000_0000, 32'h0800_0000);
    step("r_pos_31", 1'b1, 1'b0, 32'd31, 32'h4000_0000, 32'h0000_0000);
    step("r_neg_31", 1'b1, 1'b0, 32'd31, 32'h8000_0000, 32'hFFFF_FFFF);

    // Left shifts.
    step("l_31",     1'b1, 1'b1, 32'd31, 32'h0000_0001, 32'h8000_0000);
    step("l_4",      1'b1, 1'b1, 32'd4,  32'hFFFF_FFFF, 32'hFFFF_FFF0);
    step("l_13",     1'b1, 1'b1, 32'd13, 32'h0000_ABCD, 32'h1579_A000);

    // Saturation and zero amount.
    step("sat_r_32",   1'b1, 1'b0, 32'd32,        32'h8000_0000, 32'hFFFF_FFFF);
    step("sat_r_100",  1'b1, 1'b0, 32'h100,       32'h8000_0000, 32'hFFFF_FFFF);
    step("sat_r_pos",  1'b1, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000);
    step("sat_l_40",   1'b1, 1'b1, 32'd40,        32'h8000_0000, 32'h0000_0000);
    step("zero_l",     1'b1, 1'b1, 32'd0,         32'h1234_5678, 32'h1234_5678);
    step("zero_r",     1'b1, 1'b0, 32'd0,         32'h8765_4321, 32'h8765_4321);

    // Idle cycles with moving inputs, including X on the control inputs.
    step("hold_a", 1'b0, 1'b1, 32'd5,  32'hDEAD_BEEF, '0);
    step("hold_b", 1'b0, 1'bx, 'x,     32'h0BAD_F00D, '0);

    // Back-to-back burst with random operands checked against the reference.
    for (int i = 0; i < 24; i++) begin
      r_dir = 1'($urandom_range(1));
      r_amt = (i % 4 == 0) ? AMT_WIDTH'($urandom_range(255)) : AMT_WIDTH'($urandom_range(31));
      r_din = $urandom;
      step("rand", 1'b1, r_dir, r_amt, r_din, ref_shift(r_dir, r_amt, r_din));
    end

    // Asynchronous reset between edges while a result is being presented.
    step("pre_rst", 1'b1, 1'b0, 32'd4, 32'hF000_0000, 32'hFF00_0000);
    bus.in_vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_dout", bus.D_out, '0);
    chk("async_rst_vld",  {{(WIDTH-1){1'b0}}, bus.out_vld}, '0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    last_out = '0;
    step("post_rst_idle", 1'b0, 1'b0, 32'd1, 32'h8000_0000, '0);
    step("post_rst_r1",   1'b1, 1'b0, 32'd1, 32'h8000_0000, 32'hC000_0000);
    step("post_rst_end",  1'b0, 1'b0, 32'd0, 32'h0,         '0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
